// File: rtl/vga_pkg.sv
// Shared types for the video pipeline: level select, brightness range and the
// level-fade sequencer states.
package vga_pkg;

  typedef enum logic [1:0] {
    LEVEL_0,
    LEVEL_1,
    LEVEL_2,
    LEVEL_3
  } level_t;

  localparam int unsigned FADE_MAX = 15;

  typedef enum logic [1:0] {
    StIdle,
    StFadeOut,
    StSwap,
    StFadeIn
  } fade_state_e;

endpackage

// File: rtl/level_fade_ctrl_if.sv
// Request handshake from game logic plus the level/brightness outputs of the
// level fade sequencer.
interface level_fade_ctrl_if;
  import vga_pkg::*;

  logic       req_valid;
  level_t     req_level;
  logic       req_ready;
  level_t     level;
  logic [3:0] fade;
  logic       busy;
  logic       done;

  modport master (
    output req_valid,
    output req_level,
    input  req_ready,
    input  level,
    input  fade,
    input  busy,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_level,
    output req_ready,
    output level,
    output fade,
    output busy,
    output done
  );

endinterface

// File: rtl/frame_edge_det.sv
// Registers vblnk and emits a one-cycle tick on its rising edge (frame start).
module frame_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);

  logic vblnk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d <= 1'b0;
    end else begin
      vblnk_d <= vblnk;
    end
  end

  assign tick = vblnk & ~vblnk_d;

endmodule

// File: rtl/level_fade_ctrl.sv
// Applies background level changes at frame boundaries. With LEVEL_FADE_EN
// defined the picture is faded out and back in around the swap.
module level_fade_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned FADE_MAX        = vga_pkg::FADE_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vblnk,
  level_fade_ctrl_if.slave   bus
);

  import vga_pkg::*;

  localparam logic [3:0] FadeFull = 4'(FADE_MAX);

  logic        tick;
  fade_state_e state_q, state_d;
  level_t      level_q, level_d;
  level_t      target_q, target_d;
  logic        busy_q;
  logic        done_q, done_d;

  frame_edge_det u_frame_edge_det (
    .clk   (clk),
    .rst   (rst),
    .vblnk (vblnk),
    .tick  (tick)
  );

`ifdef LEVEL_FADE_EN
  localparam int unsigned CntW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FRAMES_PER_STEP - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      fade_q, fade_d;
  logic            step;

  // Tick that completes a brightness step.
  assign step = tick && (cnt_q == CntLast);
`else
  logic unused_cfg;
  assign unused_cfg = ^FRAMES_PER_STEP;
`endif

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    done_d   = 1'b0;
`ifdef LEVEL_FADE_EN
    cnt_d    = cnt_q;
    fade_d   = fade_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (bus.req_level == level_q) begin
            done_d = 1'b1;
          end else begin
            target_d = bus.req_level;
`ifdef LEVEL_FADE_EN
            cnt_d    = '0;
            state_d  = StFadeOut;
`else
            state_d  = StSwap;
`endif
          end
        end
      end

`ifdef LEVEL_FADE_EN
      StFadeOut: begin
        if (step) begin
          cnt_d  = '0;
          fade_d = (fade_q != 4'd0) ? fade_q - 4'd1 : 4'd0;
          if (fade_d == 4'd0) begin
            state_d = StSwap;
          end
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StSwap: begin
        if (tick) begin
          level_d = target_q;
          cnt_d   = '0;
          state_d = StFadeIn;
        end
      end

      StFadeIn: begin
        if (step) begin
          cnt_d  = '0;
          fade_d = (fade_q < FadeFull) ? fade_q + 4'd1 : FadeFull;
          if (fade_d == FadeFull) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`else
      StSwap: begin
        if (tick) begin
          level_d = target_q;
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      level_q  <= LEVEL_0;
      target_q <= LEVEL_0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      busy_q   <= (state_d != StIdle);
      done_q   <= done_d;
    end
  end

`ifdef LEVEL_FADE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      fade_q <= FadeFull;
    end else begin
      cnt_q  <= cnt_d;
      fade_q <= fade_d;
    end
  end

  assign bus.fade = fade_q;
`else
  assign bus.fade = FadeFull;
`endif

  assign bus.req_ready = (state_q == StIdle);
  assign bus.level     = level_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_level_fade_ctrl.sv
// Scoreboard bench for level_fade_ctrl: stimulus pushes expected completions,
// a monitor pops and checks them on every done pulse.
module tb_level_fade_ctrl;
  import vga_pkg::*;

`ifdef LEVEL_FADE_EN
  localparam int FullTicks = 61;
`else
  localparam int FullTicks = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vblnk = 1'b0;

  level_fade_ctrl_if bus ();

  level_fade_ctrl #(
    .FRAMES_PER_STEP (2),
    .FADE_MAX        (15)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .vblnk (vblnk),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    level_t lvl;
    int     fade;
    int     ticks;
    int     edges;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   tick_cnt = 0;
  int   cyc = 0;
  int   acc_tick = 0;
  int   acc_cyc = 0;
  logic vb_prev = 1'b0;
  logic vb_edge = 1'b0;
  logic rst_edge = 1'b1;

  // Independent frame-tick model.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    vb_edge  <= vblnk;
    rst_edge <= rst;
    if (rst) begin
      vb_prev <= 1'b0;
    end else begin
      vb_prev <= vblnk;
      if (vblnk && !vb_prev) tick_cnt <= tick_cnt + 1;
    end
  end

  initial begin
    forever begin
      repeat (6) @(negedge clk);
      vblnk = 1'b1;
      repeat (2) @(negedge clk);
      vblnk = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got no event expected event", name);
  endtask

  initial begin : monitor
    logic   done_prev;
    level_t lvl_prev;
    exp_t   e;
    done_prev = 1'b0;
    lvl_prev  = LEVEL_0;
    forever begin
      @(negedge clk);
      if (!rst && !rst_edge) begin
        if (bus.level != lvl_prev) chk("level_in_vblank", int'(vb_edge), 1);
        if (bus.done) begin
          chk("done_width", int'(done_prev), 0);
          if (sb.size() == 0) begin
            fail_msg("unexpected_done");
          end else begin
            e = sb.pop_front();
            chk("done_level", int'(bus.level), int'(e.lvl));
            chk("done_fade", int'(bus.fade), e.fade);
            chk("done_busy", int'(bus.busy), 0);
            chk("done_ticks", tick_cnt - acc_tick, e.ticks);
            if (e.edges >= 0) chk("done_edges", cyc - acc_cyc, e.edges);
          end
        end
      end
      done_prev = bus.done;
      lvl_prev  = bus.level;
    end
  end

  task automatic request(input level_t lv, input bit expect_wait);
    bit got;
    got = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_level = lv;
    if (expect_wait) chk("ready_while_busy", int'(bus.req_ready), 0);
    for (int k = 0; k < 4000 && !got; k++) begin
      if (bus.req_ready === 1'b1) begin
        @(posedge clk);
        #1;
        acc_tick = tick_cnt;
        acc_cyc  = cyc;
        got      = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.req_valid = 1'b0;
    if (!got) fail_msg("accept_timeout");
  endtask

  task automatic wait_tick();
    int  t0;
    bit  seen;
    t0   = tick_cnt;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (tick_cnt != t0) seen = 1'b1;
    end
    if (!seen) fail_msg("tick_timeout");
  endtask

  task automatic wait_ticks(input int n);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      if (tick_cnt - acc_tick >= n) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) fail_msg("ticks_timeout");
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      @(negedge clk);
      if (bus.busy == 1'b0) seen = 1'b1;
    end
    if (!seen) fail_msg("idle_timeout");
    @(negedge clk);
  endtask

`ifdef LEVEL_FADE_EN
  task automatic wait_fade(input int f);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      if (int'(bus.fade) == f) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) fail_msg("fade_timeout");
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0;
    bus.req_level = LEVEL_0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_level", int'(bus.level), 0);
    chk("reset_fade", int'(bus.fade), 15);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", int'(bus.req_ready), 1);
    @(negedge clk);

    // Same-level request: immediate done, no transition
    sb.push_back('{LEVEL_0, 15, 0, 0});
    request(LEVEL_0, 1'b0);
    chk("same_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("same_busy_later", int'(bus.busy), 0);
    chk("same_fade", int'(bus.fade), 15);
    repeat (2) @(negedge clk);

    // Full transition 0 -> 2
    wait_tick();
    sb.push_back('{LEVEL_2, 15, FullTicks, -1});
    request(LEVEL_2, 1'b0);
    chk("xfer_busy", int'(bus.busy), 1);
    chk("xfer_level_hold", int'(bus.level), 0);
`ifdef LEVEL_FADE_EN
    wait_ticks(30);
    chk("xfer_fade_black", int'(bus.fade), 0);
    chk("xfer_level_before_swap", int'(bus.level), 0);
    wait_ticks(31);
    chk("xfer_level_swapped", int'(bus.level), 2);
    chk("xfer_fade_at_swap", int'(bus.fade), 0);
`else
    chk("xfer_fade_const", int'(bus.fade), 15);
`endif
    wait_idle();
    chk("xfer_level_final", int'(bus.level), 2);
    chk("xfer_fade_final", int'(bus.fade), 15);

    // Reset in the middle of a transition
    wait_tick();
    sb.push_back('{LEVEL_1, 15, FullTicks, -1});
    request(LEVEL_1, 1'b0);
`ifdef LEVEL_FADE_EN
    wait_fade(7);
`else
    @(negedge clk);
`endif
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    chk("rst_mid_fade", int'(bus.fade), 15);
    chk("rst_mid_level", int'(bus.level), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_done", int'(bus.done), 0);
    chk("rst_mid_ready", int'(bus.req_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Request while busy is held off until the block returns to idle
    wait_tick();
    sb.push_back('{LEVEL_1, 15, FullTicks, -1});
    request(LEVEL_1, 1'b0);
`ifdef LEVEL_FADE_EN
    wait_ticks(10);
`else
    @(negedge clk);
`endif
    sb.push_back('{LEVEL_3, 15, FullTicks, -1});
    request(LEVEL_3, 1'b1);
    chk("held_level_after_first", int'(bus.level), 1);
    wait_idle();
    chk("held_level_final", int'(bus.level), 3);
    chk("sb_empty", sb.size(), 0);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
